// File: rtl/damage_scheduler_if.sv
// Damage offer handshake between the scheduler (master) and the health block (slave).
interface damage_scheduler_if;
  logic       dmg_valid;
  logic [2:0] dmg_out;
  logic       dmg_ready;

  modport master (output dmg_valid, output dmg_out, input dmg_ready);
  modport slave  (input dmg_valid, input dmg_out, output dmg_ready);
endinterface

// File: rtl/damage_scheduler.sv
// Round-robin hit arbiter that offers one damage amount to the health block and
// then holds the player invulnerable for INVULN_FRAMES frame edges.
module damage_scheduler #(
  parameter int INVULN_FRAMES = 60
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_clk,
  input  logic [3:0]                hit_req,
  input  logic [7:0]                hit_amt,
  input  logic [2:0]                health_in,
  input  logic                      game_over_in,
  damage_scheduler_if.master        dmg,
  output logic [3:0]                grant,
  output logic                      invuln,
  output logic [7:0]                drop_cnt
);

  localparam int CW = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(INVULN_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_INVULN = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_frame_q1, r_frame_q2;
  logic [1:0]    r_rr, w_rr_nxt;
  logic [1:0]    r_win, w_win_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_valid, w_valid_nxt;
  logic [2:0]    r_dout, w_dout_nxt;
  logic [3:0]    r_grant, w_grant_nxt;
  logic          r_invuln;
  logic [7:0]    r_drop, w_drop_nxt;
  logic          w_frame_edge;
  logic [1:0]    w_pick;
  logic [1:0]    w_amt_raw;
  logic [2:0]    w_amt;
  logic [2:0]    w_dmg;

  // First requesting source at or above ptr, wrapping; lower offsets overwrite later.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] res;
    res = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        res = idx;
      end
    end
    return res;
  endfunction

  assign w_frame_edge = r_frame_q1 & ~r_frame_q2;
  assign w_pick       = rr_pick(hit_req, r_rr);
  assign w_amt_raw    = hit_amt[{w_pick, 1'b0} +: 2];
  assign w_amt        = (w_amt_raw == 2'd0) ? 3'd1 : {1'b0, w_amt_raw};
  assign w_dmg        = (w_amt > health_in) ? health_in : w_amt;

  // Frame strobe synchroniser / edge detector
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_frame_q1 <= 1'b0;
      r_frame_q2 <= 1'b0;
    end else begin
      r_frame_q1 <= frame_clk;
      r_frame_q2 <= r_frame_q1;
    end
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_rr     <= 2'd0;
      r_win    <= 2'd0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_dout   <= 3'd0;
      r_grant  <= 4'd0;
      r_invuln <= 1'b0;
      r_drop   <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr     <= w_rr_nxt;
      r_win    <= w_win_nxt;
      r_cnt    <= w_cnt_nxt;
      r_valid  <= w_valid_nxt;
      r_dout   <= w_dout_nxt;
      r_grant  <= w_grant_nxt;
      r_invuln <= (w_state_nxt == S_INVULN);
      r_drop   <= w_drop_nxt;
    end
  end

  // Next-state and next-output logic; death overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_win_nxt   = r_win;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_dout_nxt  = r_dout;
    w_grant_nxt = 4'd0;
    w_drop_nxt  = r_drop;
    if (game_over_in || (health_in == 3'd0)) begin
      w_state_nxt = S_DEAD;
      w_valid_nxt = 1'b0;
      w_dout_nxt  = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hit_req != 4'd0) begin
            w_state_nxt = S_ISSUE;
            w_win_nxt   = w_pick;
            w_valid_nxt = 1'b1;
            w_dout_nxt  = w_dmg;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_ISSUE: begin
          if (dmg.dmg_ready) begin
            w_state_nxt = S_INVULN;
            w_grant_nxt = 4'b0001 << r_win;
            w_rr_nxt    = r_win + 2'd1;
            w_cnt_nxt   = CNT_LOAD;
            w_valid_nxt = 1'b0;
            w_dout_nxt  = 3'd0;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
        S_INVULN: begin
          if (w_frame_edge) begin
            if ((hit_req != 4'd0) && (r_drop != 8'hFF)) begin
              w_drop_nxt = r_drop + 8'd1;
            end else begin
              w_drop_nxt = r_drop;
            end
            if (r_cnt == '0) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = r_cnt - CW'(1);
            end
          end else begin
            w_state_nxt = S_INVULN;
          end
        end
        S_DEAD: begin
          w_state_nxt = S_DEAD;
          w_valid_nxt = 1'b0;
          w_dout_nxt  = 3'd0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_dout_nxt  = 3'd0;
        end
      endcase
    end
  end

  assign dmg.dmg_valid = r_valid;
  assign dmg.dmg_out   = r_dout;
  assign grant         = r_grant;
  assign invuln        = r_invuln;
  assign drop_cnt      = r_drop;

endmodule

// File: tb/tb_damage_scheduler.sv
// Directed bench for damage_scheduler: expected offers/grants are queued when a
// request is driven and compared when the scheduler presents the offer.
module tb_damage_scheduler;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic [3:0] hit_req;
  logic [7:0] hit_amt;
  logic [2:0] health_in;
  logic       game_over_in;
  logic [3:0] grant;
  logic       invuln;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [2:0] d;
  } exp_t;
  exp_t exp_q[$];

  damage_scheduler_if u_if();

  damage_scheduler #(.INVULN_FRAMES(60)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .hit_req      (hit_req),
    .hit_amt      (hit_amt),
    .health_in    (health_in),
    .game_over_in (game_over_in),
    .dmg          (u_if),
    .grant        (grant),
    .invuln       (invuln),
    .drop_cnt     (drop_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [2:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    repeat (3) tick();
    frame_clk = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    Reset_n           = 1'b0;
    hit_req           = 4'd0;
    hit_amt           = 8'd0;
    game_over_in      = 1'b0;
    u_if.dmg_ready    = 1'b0;
    frame_clk         = 1'b0;
    health_in         = 3'd5;
    repeat (2) tick();
    Reset_n = 1'b1;
  endtask

  // Waits for an offer, checks it against the scoreboard, optionally stalls, then handshakes.
  task automatic take_offer(input int hold);
    exp_t e;
    int   k;
    k = 0;
    while (u_if.dmg_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("offer_seen", {31'd0, u_if.dmg_valid}, 32'd1);
    e = exp_q.pop_front();
    chk("dmg_out", {29'd0, u_if.dmg_out}, {29'd0, e.d});
    for (int i = 0; i < hold; i++) begin
      hit_req = 4'($urandom_range(0, 15));
      tick();
      chk("hold_valid", {31'd0, u_if.dmg_valid}, 32'd1);
      chk("hold_out", {29'd0, u_if.dmg_out}, {29'd0, e.d});
      chk("hold_grant", {28'd0, grant}, 32'd0);
    end
    u_if.dmg_ready = 1'b1;
    tick();
    u_if.dmg_ready = 1'b0;
    chk("grant", {28'd0, grant}, {28'd0, e.g});
    chk("valid_after_hs", {31'd0, u_if.dmg_valid}, 32'd0);
    chk("invuln_on", {31'd0, invuln}, 32'd1);
    tick();
    chk("grant_pulse", {28'd0, grant}, 32'd0);
  endtask

  task automatic count_window(output int n);
    n = 0;
    while (invuln === 1'b1 && n < 100) begin
      frame();
      n++;
    end
  endtask

  initial begin
    int n;
    int exp_drop;

    do_reset();
    chk("rst_valid", {31'd0, u_if.dmg_valid}, 32'd0);
    chk("rst_out", {29'd0, u_if.dmg_out}, 32'd0);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_invuln", {31'd0, invuln}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);

    // Single hit from source 2, amount 2, ready already high
    hit_req        = 4'b0100;
    hit_amt        = 8'b00_10_00_00;
    u_if.dmg_ready = 1'b1;
    push(4'b0100, 3'd2);
    tick();
    hit_req = 4'd0;
    chk("first_valid", {31'd0, u_if.dmg_valid}, 32'd1);
    take_offer(0);
    count_window(n);
    chk("window_len", n, 32'd60);
    chk("window_drop", {24'd0, drop_cnt}, 32'd0);

    // All sources requesting: round-robin order and saturating drop count
    do_reset();
    hit_amt = 8'b00_11_10_01;
    hit_req = 4'b1111;
    push(4'b0001, 3'd1);
    push(4'b0010, 3'd2);
    push(4'b0100, 3'd3);
    push(4'b1000, 3'd1);
    push(4'b0001, 3'd1);
    for (int w = 0; w < 5; w++) begin
      take_offer(0);
      hit_req = 4'b1111;
      count_window(n);
      chk("rr_window_len", n, 32'd60);
      exp_drop = (w + 1) * 60;
      if (exp_drop > 255) exp_drop = 255;
      chk("rr_drop", {24'd0, drop_cnt}, exp_drop);
    end

    // Amount clipped by health, 10-cycle stall with hit_req churning
    do_reset();
    health_in = 3'd1;
    hit_amt   = 8'b00_00_00_11;
    hit_req   = 4'b0001;
    push(4'b0001, 3'd1);
    take_offer(10);

    // Zero amount is treated as one
    do_reset();
    hit_amt = 8'd0;
    hit_req = 4'b0010;
    push(4'b0010, 3'd1);
    take_offer(0);

    // Game over during ISSUE: dead until reset
    do_reset();
    hit_req = 4'b0010;
    hit_amt = 8'b00_00_10_00;
    tick();
    chk("go_issue_valid", {31'd0, u_if.dmg_valid}, 32'd1);
    game_over_in = 1'b1;
    tick();
    game_over_in = 1'b0;
    chk("dead_valid", {31'd0, u_if.dmg_valid}, 32'd0);
    chk("dead_invuln", {31'd0, invuln}, 32'd0);
    hit_req        = 4'b1111;
    u_if.dmg_ready = 1'b1;
    repeat (8) tick();
    chk("dead_stays_valid", {31'd0, u_if.dmg_valid}, 32'd0);
    chk("dead_stays_grant", {28'd0, grant}, 32'd0);
    do_reset();
    hit_req = 4'b0001;
    hit_amt = 8'b00_00_00_01;
    push(4'b0001, 3'd1);
    take_offer(0);

    // Zero health forces DEAD ahead of a pending request
    do_reset();
    health_in = 3'd0;
    hit_req   = 4'b0001;
    hit_amt   = 8'b00_00_00_01;
    tick();
    chk("h0_valid", {31'd0, u_if.dmg_valid}, 32'd0);
    health_in = 3'd5;
    repeat (2) tick();
    chk("h0_stays_dead", {31'd0, u_if.dmg_valid}, 32'd0);

    // Asynchronous reset in the middle of an invulnerability window
    do_reset();
    hit_req = 4'b0001;
    hit_amt = 8'b00_00_00_01;
    push(4'b0001, 3'd1);
    take_offer(0);
    hit_req = 4'b0001;
    repeat (7) frame();
    chk("mid_drop", {24'd0, drop_cnt}, 32'd7);
    chk("mid_invuln", {31'd0, invuln}, 32'd1);
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, u_if.dmg_valid}, 32'd0);
    chk("async_out", {29'd0, u_if.dmg_out}, 32'd0);
    chk("async_grant", {28'd0, grant}, 32'd0);
    chk("async_invuln", {31'd0, invuln}, 32'd0);
    chk("async_drop", {24'd0, drop_cnt}, 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
